// File: rtl/vga_timing_detector.sv
// vga_timing_detector
// Watches an incoming hsync/vsync pair in the pixel-clock domain. It measures
// the line length in clocks and the frame height in lines, and recovers the
// pixel coordinates. It declares lock once LOCK_FRAMES consecutive frames
// match the expected H_TOTAL x V_TOTAL geometry.
module vga_timing_detector #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        line_start,
  output logic        frame_start,
  output logic [10:0] h_total_meas,
  output logic [10:0] v_total_meas,
  output logic        locked,
  output logic        sync_err
);

  localparam logic [1:0]  ST_SEARCH  = 2'd0;
  localparam logic [1:0]  ST_MEASURE = 2'd1;
  localparam logic [1:0]  ST_LOCKED  = 2'd2;

  localparam logic [9:0]  CNT_MAX = 10'h3FF;
  localparam logic [10:0] H_EXP   = 11'(H_TOTAL);
  localparam logic [10:0] V_EXP   = 11'(V_TOTAL);
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

  logic        hs_act, vs_act;
  logic        hs_prev_q, vs_prev_q;
  logic        hs_edge, vs_edge;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [10:0] x_plus1, y_plus_hs;
  logic [10:0] h_meas_q, v_meas_q;
  logic        line_start_q, frame_start_q, sync_err_q;
  logic        h_valid_q;
  logic [1:0]  state_q, state_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic        frame_bad_q, frame_bad_d;
  logic        line_viol, stall_viol, frame_viol, viol;

  // Normalise both syncs to active-high, then detect the inactive->active edge.
  assign hs_act  = (hsync == HS_POL);
  assign vs_act  = (vsync == VS_POL);
  assign hs_edge = hs_act & ~hs_prev_q;
  assign vs_edge = vs_act & ~vs_prev_q;

  // An 11-bit sum holds a saturated count of 1023 plus one without wrapping.
  // A vsync edge that coincides with an hsync edge counts that line toward
  // the frame that is ending.
  assign x_plus1   = {1'b0, x_q} + 11'd1;
  assign y_plus_hs = {1'b0, y_q} + {10'd0, hs_edge};

  assign x_d = hs_edge         ? 10'd0   :
               (x_q == CNT_MAX) ? CNT_MAX : x_plus1[9:0];
  assign y_d = vs_edge         ? 10'd0   :
               y_plus_hs[10]   ? CNT_MAX : y_plus_hs[9:0];

  // Stall fires on the single cycle in which x steps onto its ceiling, so it
  // pulses once per stall and is re-armed when the next hsync edge clears x.
  assign line_viol  = hs_edge & h_valid_q & (x_plus1 != H_EXP);
  assign stall_viol = h_valid_q & ~hs_edge & (x_q == CNT_MAX - 10'd1);
  assign frame_viol = vs_edge & (state_q != ST_SEARCH) & (y_plus_hs != V_EXP);
  assign viol       = line_viol | stall_viol | frame_viol;

  // Lock state machine: count consecutive clean frames, drop on any violation.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    frame_bad_d = frame_bad_q;
    case (state_q)
      ST_SEARCH: begin
        if (vs_edge) begin
          state_d     = ST_MEASURE;
          good_cnt_d  = 4'd0;
          frame_bad_d = 1'b0;
        end
      end
      ST_MEASURE: begin
        if (vs_edge) begin
          frame_bad_d = 1'b0;
          if (frame_bad_q | viol) good_cnt_d = 4'd0;
          else                    good_cnt_d = good_cnt_q + 4'd1;
          if (good_cnt_d == LOCK_N) state_d = ST_LOCKED;
        end else if (viol) begin
          frame_bad_d = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (viol) begin
          // A violation on a vsync edge belongs to the frame that just ended,
          // so the new frame starts clean; otherwise the current frame is bad.
          state_d     = ST_MEASURE;
          good_cnt_d  = 4'd0;
          frame_bad_d = ~vs_edge;
        end else if (vs_edge) begin
          frame_bad_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_SEARCH;
        good_cnt_d  = 4'd0;
        frame_bad_d = 1'b0;
      end
    endcase
  end

  // Edge history, counters, measurements and event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Prior samples reset to "active" so a sync held active across reset
      // does not produce a false edge on release.
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      h_meas_q      <= 11'd0;
      v_meas_q      <= 11'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
      h_valid_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      hs_prev_q     <= hs_act;
      vs_prev_q     <= vs_act;
      x_q           <= x_d;
      y_q           <= y_d;
      if (hs_edge) h_meas_q <= x_plus1;
      if (vs_edge) v_meas_q <= y_plus_hs;
      line_start_q  <= hs_edge;
      frame_start_q <= vs_edge;
      sync_err_q    <= viol;
      h_valid_q     <= h_valid_q | hs_edge;
    end
  end

  // Lock state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SEARCH;
      good_cnt_q  <= 4'd0;
      frame_bad_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      frame_bad_q <= frame_bad_d;
    end
  end

  assign x            = x_q;
  assign y            = y_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign h_total_meas = h_meas_q;
  assign v_total_meas = v_meas_q;
  assign locked       = (state_q == ST_LOCKED);
  assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_vga_timing_detector.sv
// Testbench for vga_timing_detector. It drives two instances from one
// stimulus stream: an active-low instance and an active-high instance that
// sees inverted syncs. A reduced 100x20 geometry keeps frames short. Both
// instances are compared every cycle against an event-level reference model.
// Directed checks cover lock timing, glitches, stalls, offset vsync and reset.
module tb_vga_timing_detector;

  localparam int H    = 100;
  localparam int V    = 20;
  localparam int LF   = 2;
  localparam int HS_W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hs_raw = 1'b0;
  logic vs_raw = 1'b0;

  logic [9:0]  x0, y0, x1, y1;
  logic [10:0] hm0, vm0, hm1, vm1;
  logic        ls0, fs0, lk0, er0, ls1, fs1, lk1, er1;
  logic [63:0] pack0, pack1;

  always #5 clk = ~clk;

  vga_timing_detector #(
    .H_TOTAL(H), .V_TOTAL(V), .LOCK_FRAMES(LF), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_lo (
    .clk(clk), .rst_n(rst_n), .hsync(~hs_raw), .vsync(~vs_raw),
    .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0),
    .h_total_meas(hm0), .v_total_meas(vm0), .locked(lk0), .sync_err(er0)
  );

  vga_timing_detector #(
    .H_TOTAL(H), .V_TOTAL(V), .LOCK_FRAMES(LF), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_hi (
    .clk(clk), .rst_n(rst_n), .hsync(hs_raw), .vsync(vs_raw),
    .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1),
    .h_total_meas(hm1), .v_total_meas(vm1), .locked(lk1), .sync_err(er1)
  );

  assign pack0 = {18'd0, x0, y0, ls0, fs0, hm0, vm0, lk0, er0};
  assign pack1 = {18'd0, x1, y1, ls1, fs1, hm1, vm1, lk1, er1};

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model, in terms of unbounded clock/line counts since the last sync edges.
  bit m_hs_prev, m_vs_prev, m_h_seen, m_ls, m_fs, m_err, m_bad;
  int m_clk, m_lines, m_hmeas, m_vmeas, m_phase, m_run;  // phase: 0 search, 1 measure, 2 locked

  function automatic void model_reset();
    m_hs_prev = 1'b1; m_vs_prev = 1'b1; m_h_seen = 1'b0;
    m_clk = 0; m_lines = 0; m_hmeas = 0; m_vmeas = 0;
    m_ls = 1'b0; m_fs = 1'b0; m_err = 1'b0;
    m_phase = 0; m_run = 0; m_bad = 1'b0;
  endfunction

  function automatic void model_step(input bit hs, input bit vs);
    bit hs_e, vs_e, viol;
    int line_len, frame_h, nclk;
    hs_e     = hs && !m_hs_prev;
    vs_e     = vs && !m_vs_prev;
    line_len = ((m_clk > 1023) ? 1023 : m_clk) + 1;
    frame_h  = ((m_lines > 1023) ? 1023 : m_lines) + int'(hs_e);
    nclk     = hs_e ? 0 : m_clk + 1;
    viol     = (hs_e && m_h_seen && line_len != H) ||
               (m_h_seen && nclk == 1023) ||
               (vs_e && m_phase != 0 && frame_h != V);
    if (hs_e) m_hmeas = line_len;
    if (vs_e) m_vmeas = frame_h;
    if (m_phase == 0) begin
      if (vs_e) begin m_phase = 1; m_run = 0; m_bad = 1'b0; end
    end else if (m_phase == 1) begin
      if (vs_e) begin
        m_run = (m_bad || viol) ? 0 : m_run + 1;
        m_bad = 1'b0;
        if (m_run == LF) m_phase = 2;
      end else if (viol) m_bad = 1'b1;
    end else begin
      if (viol) begin m_phase = 1; m_run = 0; m_bad = !vs_e; end
      else if (vs_e) m_bad = 1'b0;
    end
    m_lines   = vs_e ? 0 : m_lines + int'(hs_e);
    m_clk     = nclk;
    m_h_seen  = m_h_seen || hs_e;
    m_hs_prev = hs;
    m_vs_prev = vs;
    m_ls      = hs_e;
    m_fs      = vs_e;
    m_err     = viol;
  endfunction

  function automatic logic [63:0] model_pack();
    int xc, yc;
    xc = (m_clk > 1023) ? 1023 : m_clk;
    yc = (m_lines > 1023) ? 1023 : m_lines;
    return {18'd0, 10'(xc), 10'(yc), m_ls, m_fs, 11'(m_hmeas), 11'(m_vmeas),
            (m_phase == 2), m_err};
  endfunction

  task automatic compare_all();
    logic [63:0] exp;
    exp = model_pack();
    check("outputs_lo", pack0, exp);
    check("outputs_hi", pack1, exp);
  endtask

  // Event bookkeeping from the active-low instance, for directed window checks.
  int err_cnt = 0;
  int fs_cnt = 0;
  int lock_fs = -1;
  int unlock_cnt = 0;
  int err_hmeas = 0;
  bit lk_prev = 1'b0;

  task automatic tick(input bit hs, input bit vs);
    @(negedge clk);
    hs_raw = hs;
    vs_raw = vs;
    if (rst_n) model_step(hs, vs);
    else       model_reset();
    @(posedge clk);
    #1;
    compare_all();
    if (er0) begin err_cnt++; err_hmeas = int'(hm0); end
    if (fs0) fs_cnt++;
    if (lk0 && !lk_prev) lock_fs = fs_cnt;
    if (!lk0 && lk_prev) unlock_cnt++;
    lk_prev = lk0;
  endtask

  // One frame: vsync active for two lines starting vs_off clocks into the frame.
  task automatic send_frame(input int n_lines, input int vs_off, input int bad_line,
                            input int bad_len, input int hs_w);
    int p, len;
    p = 0;
    for (int l = 0; l < n_lines; l++) begin
      len = (l == bad_line) ? bad_len : H;
      for (int c = 0; c < len; c++) begin
        tick(c < hs_w, (p >= vs_off) && (p < vs_off + 2 * H));
        p++;
      end
    end
  endtask

  initial begin
    model_reset();

    // Reset held with toggling syncs: everything stays at reset values.
    repeat (20) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("reset_locked", lk0, 64'd0);
    rst_n = 1'b1;
    repeat (5) tick(1'b0, 1'b0);

    // Clean aligned stream: lock at the 3rd frame_start, no errors.
    err_cnt = 0; fs_cnt = 0; lock_fs = -1;
    repeat (4) send_frame(V, 0, -1, H, HS_W);
    check("clean_lock_at_fs", 64'(lock_fs), 64'd3);
    check("clean_no_err", 64'(err_cnt), 64'd0);
    check("clean_h_meas", hm0, 64'(H));
    check("clean_v_meas", vm0, 64'(V));

    // One line one clock too long while locked.
    err_cnt = 0;
    send_frame(V, 0, 5, H + 1, HS_W);
    check("glitch_err_cnt", 64'(err_cnt), 64'd1);
    check("glitch_h_meas", 64'(err_hmeas), 64'(H + 1));
    check("glitch_unlocked", lk0, 64'd0);
    repeat (3) send_frame(V, 0, -1, H, HS_W);
    check("glitch_relock", lk0, 64'd1);

    // hsync stall of 2000 clocks while locked.
    err_cnt = 0; unlock_cnt = 0;
    repeat (2000) tick(1'b0, 1'b0);
    check("stall_err_cnt", 64'(err_cnt), 64'd1);
    check("stall_x_sat", x0, 64'd1023);
    check("stall_unlocked", lk0, 64'd0);
    check("stall_unlock_cnt", 64'(unlock_cnt), 64'd1);
    repeat (4) send_frame(V, 0, -1, H, HS_W);
    check("stall_h_meas", hm0, 64'(H));
    check("stall_relock", lk0, 64'd1);

    // vsync offset from hsync: same height, lock held; then one short frame.
    err_cnt = 0;
    repeat (4) send_frame(V, 37, -1, H, HS_W);
    check("offset_no_err", 64'(err_cnt), 64'd0);
    check("offset_v_meas", vm0, 64'(V));
    check("offset_locked", lk0, 64'd1);
    err_cnt = 0;
    send_frame(V - 1, 37, -1, H, HS_W);
    send_frame(V, 37, -1, H, HS_W);
    check("short_err_cnt", 64'(err_cnt), 64'd1);
    check("short_v_meas", vm0, 64'(V - 1));
    check("short_unlocked", lk0, 64'd0);
    repeat (3) send_frame(V, 37, -1, H, HS_W);
    check("short_relock", lk0, 64'd1);

    // Randomised frames: offsets, sync widths, odd lines and odd heights.
    for (int f = 0; f < 8; f++) begin
      int nl, bl, blen;
      nl = V;
      if ($urandom_range(0, 5) == 0) nl = $urandom_range(0, 1) ? V + 1 : V - 1;
      bl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, V - 2)) : -1;
      blen = H - 3 + int'($urandom_range(0, 6));
      send_frame(nl, int'($urandom_range(0, H - 1)), bl, blen, int'($urandom_range(1, 30)));
    end

    // Reset asserted mid-frame, asynchronously.
    for (int i = 0; i < 1000; i++) tick((i % H) < HS_W, i < 2 * H);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("midrst_x", x0, 64'd0);
    check("midrst_locked", lk0, 64'd0);
    repeat (5) tick(1'b1, 1'b1);
    rst_n = 1'b1;
    repeat (5) send_frame(V, 0, -1, H, HS_W);
    check("midrst_relock", lk0, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_detector.md
# vga_timing_detector

Sink-side companion to the VGA timing generator. It watches an incoming hsync/vsync pair in the pixel-clock domain and measures line length (clocks) and frame height (lines). It recovers pixel coordinates and declares lock once consecutive frames match the expected 800x525 geometry. It sits at the input of the capture/loopback path and lets the bench or a downstream block check generator output in-system.

## Interface
- H_TOTAL, 800: expected clocks per line (hsync assertion to hsync assertion).
- V_TOTAL, 525: expected lines per frame.
- LOCK_FRAMES, 2: consecutive good frames required to assert lock (1..15).
- HS_POL, 0: hsync active level (0 = active-low).
- VS_POL, 0: vsync active level (0 = active-low).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  reset; asynchronous, active-low.
- hsync  in  1  horizontal sync, synchronous to clk.
- vsync  in  1  vertical sync, synchronous to clk.
- x  out  10  clocks since last hsync assertion (saturating).
- y  out  10  hsync assertions since last vsync assertion (saturating).
- line_start  out  1  one-cycle pulse on hsync assertion.
- frame_start  out  1  one-cycle pulse on vsync assertion.
- h_total_meas  out  11  last measured line length in clocks.
- v_total_meas  out  11  last measured frame height in lines.
- locked  out  1  geometry matches H_TOTAL/V_TOTAL.
- sync_err  out  1  one-cycle pulse on any geometry violation.

## Operation
- **Polarity and edge detect.** Polarity-correct the inputs: hs_act = hsync ^ ~HS_POL (same for vs). Register one prior sample of each. An hs_edge occurs when hs_act is 1 now and the prior sample is 0; vs_edge is defined the same way. The prior samples reset to 1, so there is no false edge out of reset.
- **Horizontal counter.**
  - On hs_edge: capture h_total_meas <= x+1, then x <= 0.
  - Otherwise x increments, saturating at 1023.
  - h_valid is set by the first hs_edge after reset. Only line lengths captured while h_valid=1 are checked.
- **Vertical counter.**
  - On vs_edge: capture v_total_meas <= y + hs_edge, then y <= 0.
  - Otherwise y <= y + hs_edge, saturating at 1023.
  - A coincident hsync edge counts toward the ending frame. This makes a vsync that is aligned with hsync and a vsync that is offset from it measure the same height.
- **Violations** (sync_err pulses, frame_bad set):
  - (a) hs_edge with h_valid=1 and x+1 != H_TOTAL.
  - (b) x reaches 1023 (pulses once per stall; re-armed by next hs_edge).
  - (c) vs_edge with y + hs_edge != V_TOTAL while state is not SEARCH.
- **State machine.** good_cnt is 4 bits.
  - SEARCH: wait for vs_edge, then go to MEASURE with good_cnt=0 and frame_bad=0.
  - MEASURE, on vs_edge:
    - If the frame was good and y+hs_edge==V_TOTAL, increment good_cnt.
    - Otherwise set good_cnt=0.
    - If good_cnt reaches LOCK_FRAMES, go to LOCKED.
    - frame_bad clears at each vs_edge.
  - LOCKED: any violation sends the FSM to MEASURE with good_cnt=0. The violating cycle's frame is counted as bad.
  - Outputs: locked=1 only in LOCKED.

## Timing
- **Reset values.** All outputs 0, state SEARCH, h_valid=0, good_cnt=0, frame_bad=0.
- **Edge latency.** Let T be the first cycle in which sampled hsync is active. line_start, x=0 and the new h_total_meas are visible in cycle T+1. frame_start, y=0 and v_total_meas behave the same way for vsync.
- **sync_err.** Visible in cycle T+1 relative to the violating sample.
- **Lock/unlock.** locked rises in the same cycle as the frame_start that completes the LOCK_FRAMES-th good frame. locked falls in the same cycle as the sync_err that causes it.
- **Simultaneous events.** hs_edge and vs_edge together: both counters reset. v_total_meas includes that hsync, and the line check (a) still applies.
- **Reset mid-operation.** Asserting rst_n low forces reset values asynchronously. After release, no check is made until a new hs_edge or vs_edge arrives.
- **Widths.** x and y are 10-bit. Measured values are 11-bit so a 1024 count is represented without wrap.

## Test plan
- **Reset.** Hold rst_n=0 with toggling syncs, then release -> all outputs 0 and locked=0 until the first frame_start.
- **Clean stream.** 800x525 active-low stream, 96-clock hsync, vsync aligned to hsync, 4 frames -> h_total_meas=800, v_total_meas=525 from the second frame_start. locked rises at the 3rd frame_start (LOCK_FRAMES=2). sync_err never pulses.
- **Line glitch.** While locked, make one line 801 clocks -> a single sync_err pulse with h_total_meas=801. locked drops in the same cycle, then re-asserts 2 full good frames after the next frame_start.
- **Stall.** While locked, hold hsync inactive for 2000 clocks -> x sticks at 1023 and exactly one sync_err pulse occurs. locked=0. Normal lines afterwards give h_total_meas resumes 800.
- **Offset vsync.** Move the vsync assertion 100 clocks after the hsync assertion -> v_total_meas=525 and lock is still achieved. Also make one frame 524 lines -> sync_err on that frame_start, and locked drops.
- **Polarity and reset.** Set HS_POL=VS_POL=1 with active-high syncs -> same results as the clean stream. Assert rst_n mid-frame -> outputs return to 0 immediately and state is SEARCH.
